usb_fs_in_rr_arb: RTL and testbench

//  Registered round-robin arbiter that shares the single IN protocol engine among NUM_IN_EPS endpoints.

---
 rtl/usb_fs_pkg.sv | 23 ++
 rtl/usb_fs_rr_pick.sv | 49 ++++
 rtl/usb_fs_in_rr_arb.sv | 195 +++++++++++++++++++
 tb/tb_usb_fs_in_rr_arb.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_fs_pkg.sv
// ----------------------------------------------------------------------------
// usb_fs_pkg
//   Shared definitions for the full-speed USB device blocks.
//   - arb_state_t : state encoding of the registered IN-endpoint arbiter
//   - clog2()     : ceiling log2 with a minimum result of 1, so it can size
//                   index and counter vectors even when the count is 1
// ----------------------------------------------------------------------------
package usb_fs_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/usb_fs_rr_pick.sv
// ----------------------------------------------------------------------------
// usb_fs_rr_pick
//   Combinational round-robin picker: returns the first set request bit at or
//   after ptr, wrapping past N-1 back to 0.
// Ports
//   req   in  N      request vector
//   ptr   in  IDX_W  search start index (always < N)
//   found out 1      at least one request is set
//   idx   out IDX_W  chosen index (0 when nothing is found)
// ----------------------------------------------------------------------------
module usb_fs_rr_pick
  import usb_fs_pkg::*;
#(
  parameter int N     = 1,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic             hit_hi;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    found  = 1'b0;
    hit_hi = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    // Scan downwards so the last hit written is the lowest index. idx_hi is
    // the lowest requester at or above ptr; idx_lo is the wrap-around answer.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found  = 1'b1;
        idx_lo = IDX_W'(i);
        if (IDX_W'(i) >= ptr) begin
          hit_hi = 1'b1;
          idx_hi = IDX_W'(i);
        end
      end
    end
    idx = hit_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/usb_fs_in_rr_arb.sv
// ----------------------------------------------------------------------------
// usb_fs_in_rr_arb
//   Registered round-robin arbiter sharing the IN protocol engine among
//   NUM_IN_EPS endpoints. Grants are sticky while the owner requests, are not
//   withdrawn while the PE is mid-packet (DRAIN), and a watchdog revokes a
//   grant that sees neither data puts nor PE activity for TIMEOUT_CYCLES.
// Parameters
//   NUM_IN_EPS      1..16 endpoints
//   TIMEOUT_CYCLES  idle-grant limit in clk cycles, 0 disables the watchdog
// Ports
//   clk, reset       48 MHz clock, synchronous active-high reset
//   in_ep_req        per-endpoint request (level)
//   in_ep_grant      registered one-hot grant
//   in_ep_data       per-endpoint byte, ep i at [8i+7:8i]
//   in_ep_data_put   per-endpoint byte strobe
//   pe_busy          IN PE mid-transaction
//   arb_in_ep_data   byte of granted ep, 8'h00 without a grant
//   arb_in_ep_put    put strobe of granted ep
//   grant_valid      a grant is held
//   grant_idx        index of granted ep (0 when none)
//   arb_timeout      one-cycle pulse when the watchdog revokes a grant
// ----------------------------------------------------------------------------
module usb_fs_in_rr_arb
  import usb_fs_pkg::*;
#(
  parameter  int NUM_IN_EPS     = 1,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int IDX_W          = clog2(NUM_IN_EPS),
  localparam int WD_W           = clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN_EPS-1:0]   in_ep_req,
  output logic [NUM_IN_EPS-1:0]   in_ep_grant,
  input  logic [8*NUM_IN_EPS-1:0] in_ep_data,
  input  logic [NUM_IN_EPS-1:0]   in_ep_data_put,
  input  logic                    pe_busy,
  output logic [7:0]              arb_in_ep_data,
  output logic                    arb_in_ep_put,
  output logic                    grant_valid,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    arb_timeout
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN_EPS - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic [NUM_IN_EPS-1:0] grant_d;
  logic                  grant_valid_d;
  logic [IDX_W-1:0]      grant_idx_d;
  logic                  timeout_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  cur_req;
  logic                  cur_put;
  logic [7:0]            cur_data;
  logic [IDX_W-1:0]      next_ptr;
  logic                  wd_clear;
  logic                  wd_expire;

  usb_fs_rr_pick #(
    .N     (NUM_IN_EPS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (in_ep_req),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Select the owner's request, strobe and byte from the registered index.
  always_comb begin
    cur_req  = 1'b0;
    cur_put  = 1'b0;
    cur_data = 8'h00;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        cur_req  = in_ep_req[i];
        cur_put  = in_ep_data_put[i];
        cur_data = in_ep_data[8*i +: 8];
      end
    end
  end

  assign arb_in_ep_put  = grant_valid & cur_put;
  assign arb_in_ep_data = grant_valid ? cur_data : 8'h00;

  // Explicit wrap keeps the pointer legal for non-power-of-2 endpoint counts.
  assign next_ptr  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  // Any byte movement or PE activity counts as life on the granted endpoint.
  assign wd_clear  = arb_in_ep_put | pe_busy;
  assign wd_expire = (TIMEOUT_CYCLES != 0) && !wd_clear && (wd_cnt_q == WD_LAST);

  always_comb begin
    state_d       = state_q;
    grant_d       = in_ep_grant;
    grant_valid_d = grant_valid;
    grant_idx_d   = grant_idx;
    rr_ptr_d      = rr_ptr_q;
    wd_cnt_d      = '0;
    timeout_d     = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        // Grant is taken only from IDLE, so every release costs one idle cycle.
        if (pick_found) begin
          state_d       = ARB_GRANT;
          grant_valid_d = 1'b1;
          grant_idx_d   = pick_idx;
          for (int i = 0; i < NUM_IN_EPS; i++) begin
            grant_d[i] = (pick_idx == IDX_W'(i));
          end
        end
      end

      ARB_GRANT: begin
        if (!cur_req) begin
          // A request drop wins over a coincident watchdog expiry.
          if (pe_busy) begin
            state_d = ARB_DRAIN;
          end else begin
            state_d       = ARB_IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
            grant_idx_d   = '0;
            rr_ptr_d      = next_ptr;
          end
        end else if (wd_expire) begin
          state_d       = ARB_IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_idx_d   = '0;
          rr_ptr_d      = next_ptr;
          timeout_d     = 1'b1;
        end else if (wd_clear) begin
          wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_MAX) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q;
        end
      end

      ARB_DRAIN: begin
        // A re-asserted request is ignored here; the owner must re-arbitrate.
        if (!pe_busy) begin
          state_d       = ARB_IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_idx_d   = '0;
          rr_ptr_d      = next_ptr;
        end
      end

      default: begin
        state_d       = ARB_IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ARB_IDLE;
      in_ep_grant <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      rr_ptr_q    <= '0;
      wd_cnt_q    <= '0;
      arb_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ep_grant <= grant_d;
      grant_valid <= grant_valid_d;
      grant_idx   <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      wd_cnt_q    <= wd_cnt_d;
      arb_timeout <= timeout_d;
    end
  end

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(in_ep_grant));
  a_grant_valid   : assert property (@(posedge clk) disable iff (reset) grant_valid == (|in_ep_grant));

endmodule

// File: tb/tb_usb_fs_in_rr_arb.sv
// ----------------------------------------------------------------------------
// tb_usb_fs_in_rr_arb
//   Scoreboard bench for usb_fs_in_rr_arb with 4 endpoints and an 8-cycle
//   watchdog. A driver applies directed and random stimulus, advances a
//   behavioural model of the arbitration rules and queues the expected output
//   for that cycle; a monitor pops and compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_usb_fs_in_rr_arb;

  localparam int N = 4;
  localparam int T = 8;

  logic           clk;
  logic           reset;
  logic [N-1:0]   in_ep_req;
  logic [N-1:0]   in_ep_grant;
  logic [8*N-1:0] in_ep_data;
  logic [N-1:0]   in_ep_data_put;
  logic           pe_busy;
  logic [7:0]     arb_in_ep_data;
  logic           arb_in_ep_put;
  logic           grant_valid;
  logic [1:0]     grant_idx;
  logic           arb_timeout;

  usb_fs_in_rr_arb #(
    .NUM_IN_EPS     (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_ep_req      (in_ep_req),
    .in_ep_grant    (in_ep_grant),
    .in_ep_data     (in_ep_data),
    .in_ep_data_put (in_ep_data_put),
    .pe_busy        (pe_busy),
    .arb_in_ep_data (arb_in_ep_data),
    .arb_in_ep_put  (arb_in_ep_put),
    .grant_valid    (grant_valid),
    .grant_idx      (grant_idx),
    .arb_timeout    (arb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] grant;
    logic         valid;
    logic [1:0]   idx;
    logic         timeout;
    logic [7:0]   data;
    logic         put;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: owner is the granted endpoint or -1; quiet counts consecutive
  // granted cycles with no put on the owner and no PE activity.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_quiet = 0;
  int m_held  = 0;
  bit m_drain = 1'b0;
  bit m_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic release_owner();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_drain = 1'b0;
    m_quiet = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit picked;
    m_pulse = 1'b0;
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_drain = 1'b0;
      m_quiet = 0;
    end else if (m_owner < 0) begin
      picked = 1'b0;
      for (int k = 0; k < N; k++) begin
        int e;
        e = (m_ptr + k) % N;
        if (!picked && in_ep_req[e]) begin
          picked  = 1'b1;
          m_owner = e;
          m_quiet = 0;
          m_held  = 0;
        end
      end
    end else begin
      m_held++;
      if (m_drain) begin
        if (!pe_busy) release_owner();
      end else if (!in_ep_req[m_owner]) begin
        if (pe_busy) m_drain = 1'b1;
        else release_owner();
      end else if (!in_ep_data_put[m_owner] && !pe_busy) begin
        m_quiet++;
        if (m_quiet == T) begin
          release_owner();
          m_pulse = 1'b1;
        end
      end else begin
        m_quiet = 0;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x = '0;
    if (m_owner >= 0) begin
      x.grant[m_owner] = 1'b1;
      x.valid          = 1'b1;
      x.idx            = 2'(m_owner);
      x.data           = in_ep_data[8*m_owner +: 8];
      x.put            = in_ep_data_put[m_owner];
    end
    x.timeout = m_pulse;
    return x;
  endfunction

  // One clock: the edge consumes the previous inputs, then new ones are driven.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] p, input logic b, input logic rs);
    @(posedge clk);
    model_edge();
    #1;
    in_ep_req      = r;
    in_ep_data_put = p;
    pe_busy        = b;
    reset          = rs;
    in_ep_data     = $urandom;
    sb.push_back(model_out());
  endtask

  // Monitor: compare whatever the driver queued for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("in_ep_grant",    32'(in_ep_grant),    32'(e.grant));
        check("grant_valid",    32'(grant_valid),    32'(e.valid));
        check("grant_idx",      32'(grant_idx),      32'(e.idx));
        check("arb_timeout",    32'(arb_timeout),    32'(e.timeout));
        check("arb_in_ep_data", 32'(arb_in_ep_data), 32'(e.data));
        check("arb_in_ep_put",  32'(arb_in_ep_put),  32'(e.put));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] p;
    logic         b;
    int           put_mode;

    reset          = 1'b1;
    in_ep_req      = '0;
    in_ep_data_put = '0;
    pe_busy        = 1'b0;
    in_ep_data     = '0;

    repeat (2) step(4'b0000, 4'b0000, 1'b0, 1'b1);

    // Basic grant, release and hand-over to the next requester.
    repeat (3) step(4'b0110, 4'b0000, 1'b0, 1'b0);
    repeat (3) step(4'b0100, 4'b0000, 1'b0, 1'b0);
    repeat (2) step(4'b0000, 4'b0000, 1'b0, 1'b0);

    // All endpoints requesting; each owner drops after holding 3 cycles.
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int c = 0; c < 30; c++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_held >= 3) r[m_owner] = 1'b0;
      step(r, 4'b0000, 1'b0, 1'b0);
    end
    repeat (2) step(4'b0000, 4'b0000, 1'b0, 1'b0);

    // Drain: request drops while the PE is busy, reasserts mid-drain.
    repeat (2) step(4'b0100, 4'b0000, 1'b0, 1'b0);
    repeat (2) step(4'b0100, 4'b0000, 1'b1, 1'b0);
    repeat (2) step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 4'b0000, 1'b0, 1'b0);

    // Watchdog: ep0 holds without activity, then ep1 takes over.
    repeat (14) step(4'b0011, 4'b0000, 1'b0, 1'b0);
    repeat (2) step(4'b0000, 4'b0000, 1'b0, 1'b0);

    // Owner puts every 5 cycles, others put randomly; no timeout expected.
    for (int c = 0; c < 30; c++) begin
      p = 4'($urandom);
      if (m_owner >= 0) p[m_owner] = (c % 5 == 0);
      step(4'b0101, p, 1'b0, 1'b0);
    end
    repeat (2) step(4'b0000, 4'b0000, 1'b0, 1'b0);

    // Reset during DRAIN with the PE busy; the pointer must return to 0.
    repeat (2) step(4'b0100, 4'b0000, 1'b0, 1'b0);
    repeat (2) step(4'b0000, 4'b0000, 1'b0, 1'b0);
    repeat (2) step(4'b0010, 4'b0000, 1'b0, 1'b0);
    step(4'b0010, 4'b0000, 1'b1, 1'b0);
    repeat (2) step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b1);
    repeat (3) step(4'b1010, 4'b0000, 1'b0, 1'b0);
    repeat (2) step(4'b0000, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b1);
    repeat (3) step(4'b1000, 4'b0000, 1'b0, 1'b0);
    repeat (2) step(4'b0000, 4'b0000, 1'b0, 1'b0);

    // Random traffic in 50-cycle windows with and without put activity.
    r        = '0;
    b        = 1'b0;
    put_mode = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 50 == 0) put_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) b = (put_mode == 2) ? 1'($urandom) : 1'b0;
      p = (put_mode == 0) ? 4'b0000 : 4'($urandom & $urandom);
      step(r, p, b, ($urandom_range(0, 299) == 0));
    end

    repeat (3) step(4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
